// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: dual-port block-RAM controller with per-port request/done handshake and collision arbitration
module ram_port_ctrl #(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 15,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  isRequestA,
  input  logic [DATA_W/8-1:0]   weA,
  input  logic [ADDR_W-1:0]     addrA,
  input  logic [DATA_W-1:0]     dinA,
  output logic [DATA_W-1:0]     doutA,
  output logic                  requestDoneA,
  output logic                  readValidA,
  input  logic                  isRequestB,
  input  logic [DATA_W/8-1:0]   weB,
  input  logic [ADDR_W-1:0]     addrB,
  input  logic [DATA_W-1:0]     dinB,
  output logic [DATA_W-1:0]     doutB,
  output logic                  requestDoneB,
  output logic                  readValidB,
  output logic [15:0]           collisionCount
);
  localparam int BYTES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, VALID} state_t;
  state_t            state_q [2];
  state_t            state_d [2];
  logic [BYTES-1:0]  we_q [2], we_d [2], we_in [2];
  logic [ADDR_W-1:0] addr_q [2], addr_d [2], addr_in [2];
  logic [DATA_W-1:0] din_q [2], din_d [2], din_in [2];
  logic [DATA_W-1:0] rd_q [2], dout [2];
  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0]        req, done, valid, wr_en, rd_en;
  logic              coll;
  logic [15:0]       cnt_q, cnt_d;

  assign req           = {isRequestB, isRequestA};
  assign we_in[0]      = weA;
  assign we_in[1]      = weB;
  assign addr_in[0]    = addrA;
  assign addr_in[1]    = addrB;
  assign din_in[0]     = dinA;
  assign din_in[1]     = dinB;
  assign doutA         = dout[0];
  assign doutB         = dout[1];
  assign requestDoneA  = done[0];
  assign requestDoneB  = done[1];
  assign readValidA    = valid[0];
  assign readValidB    = valid[1];
  assign collisionCount = cnt_q;

  // Per-port handshake FSM; port B holds in ISSUE for one cycle when it collides with A
  always_comb begin
    coll = state_q[0] == ISSUE && state_q[1] == ISSUE && addr_q[0] == addr_q[1] && (|we_q[0] || |we_q[1]);
    cnt_d = coll && cnt_q != 16'hFFFF ? cnt_q + 16'd1 : cnt_q;
    for (int p = 0; p < 2; p++) begin
      done[p]    = state_q[p] == IDLE || state_q[p] == VALID;
      valid[p]   = state_q[p] == VALID;
      wr_en[p]   = !rst && state_q[p] == ISSUE && |we_q[p] && !(p == 1 && coll);
      rd_en[p]   = state_q[p] == ISSUE && ~|we_q[p] && !(p == 1 && coll);
      we_d[p]    = done[p] && req[p] ? we_in[p] : we_q[p];
      addr_d[p]  = done[p] && req[p] ? addr_in[p] : addr_q[p];
      din_d[p]   = done[p] && req[p] ? din_in[p] : din_q[p];
      state_d[p] = done[p] && req[p] ? ISSUE :
                   state_q[p] == VALID ? IDLE :
                   state_q[p] == WAIT ? VALID :
                   (wr_en[p] || (state_q[p] == ISSUE && |we_q[p] && !(p == 1 && coll))) ? IDLE :
                   rd_en[p] ? (READ_LATENCY == 2 ? WAIT : VALID) : state_q[p];
    end
  end

  // State and latched-request registers; request fields need no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '{IDLE, IDLE};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    we_q   <= we_d;
    addr_q <= addr_d;
    din_q  <= din_d;
  end

  // Shared RAM array: byte-masked writes and registered reads per port
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < BYTES; i++)
        if (wr_en[p] && we_q[p][i]) mem[addr_q[p]][8*i +: 8] <= din_q[p][8*i +: 8];
      rd_q[p] <= rst ? '0 : rd_en[p] ? mem[addr_q[p]] : rd_q[p];
    end
  end

  if (READ_LATENCY == 2) begin : g_oreg
    logic [DATA_W-1:0] dout_q [2], dout_d [2];
    // Output register loads the RAM read data on leaving WAIT
    always_comb begin
      for (int p = 0; p < 2; p++) dout_d[p] = state_q[p] == WAIT ? rd_q[p] : dout_q[p];
    end
    // Output register update
    always_ff @(posedge clk) begin
      if (rst) dout_q <= '{default: '0};
      else dout_q <= dout_d;
    end
    assign dout = dout_q;
  end else begin : g_noreg
    assign dout = rd_q;
  end
endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: directed vector table plus multi-cycle sequences for ram_port_ctrl
module tb_ram_port_ctrl;
  logic        clk = 0, rst = 1;
  logic        req_a = 0, req_b = 0, done_a, done_b, valid_a, valid_b;
  logic [3:0]  we_a = 0, we_b = 0;
  logic [14:0] addr_a = 0, addr_b = 0;
  logic [31:0] din_a = 0, din_b = 0, dout_a, dout_b;
  logic [15:0] cnt;
  logic        r2_req_a = 0, r2_req_b = 0, r2_done_a, r2_done_b, r2_valid_a, r2_valid_b;
  logic [3:0]  r2_we_a = 0;
  logic [14:0] r2_addr_a = 0, r2_addr_b = 0;
  logic [31:0] r2_din_a = 0, r2_dout_a, r2_dout_b;
  logic [15:0] r2_cnt;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  ram_port_ctrl #(.READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .isRequestA(req_a), .weA(we_a), .addrA(addr_a), .dinA(din_a), .doutA(dout_a),
    .requestDoneA(done_a), .readValidA(valid_a),
    .isRequestB(req_b), .weB(we_b), .addrB(addr_b), .dinB(din_b), .doutB(dout_b),
    .requestDoneB(done_b), .readValidB(valid_b), .collisionCount(cnt));

  ram_port_ctrl #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst),
    .isRequestA(r2_req_a), .weA(r2_we_a), .addrA(r2_addr_a), .dinA(r2_din_a), .doutA(r2_dout_a),
    .requestDoneA(r2_done_a), .readValidA(r2_valid_a),
    .isRequestB(r2_req_b), .weB(4'h0), .addrB(r2_addr_b), .dinB(32'h0), .doutB(r2_dout_b),
    .requestDoneB(r2_done_b), .readValidB(r2_valid_b), .collisionCount(r2_cnt));

  typedef struct {
    logic ra; logic [3:0] wa; logic [14:0] aa; logic [31:0] da;
    logic rb; logic [3:0] wb; logic [14:0] ab; logic [31:0] db;
    logic eda; logic eva; logic [31:0] eqa;
    logic edb; logic evb; logic [31:0] eqb;
    logic [15:0] ec;
  } vec_t;
  vec_t v [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d2 [3];
    int n, last, low, maxlow, pulses;
    v[0]  = '{1'b1, 4'hF, 15'h10,  32'hDEADBEEF, 1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        16'd0};
    v[1]  = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        16'd0};
    v[2]  = '{1'b1, 4'h0, 15'h10,  32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        16'd0};
    v[3]  = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        16'd0};
    v[4]  = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 4'h3, 15'h10,  32'h00001122, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        16'd0};
    v[5]  = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        16'd0};
    v[6]  = '{1'b1, 4'h0, 15'h10,  32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        16'd0};
    v[7]  = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 1'b1, 32'hDEAD1122, 1'b1, 1'b0, 32'h0,        16'd0};
    v[8]  = '{1'b1, 4'hF, 15'h100, 32'hCAFEF00D, 1'b1, 4'h0, 15'h100, 32'h0,        1'b0, 1'b0, 32'hDEAD1122, 1'b0, 1'b0, 32'h0,        16'd0};
    v[9]  = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 1'b0, 32'hDEAD1122, 1'b0, 1'b0, 32'h0,        16'd1};
    v[10] = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 1'b0, 32'hDEAD1122, 1'b1, 1'b1, 32'hCAFEF00D, 16'd1};
    v[11] = '{1'b1, 4'hF, 15'h1,   32'h11223344, 1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 1'b0, 32'hDEAD1122, 1'b1, 1'b0, 32'hCAFEF00D, 16'd1};
    v[12] = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 1'b0, 32'hDEAD1122, 1'b1, 1'b0, 32'hCAFEF00D, 16'd1};
    v[13] = '{1'b1, 4'h0, 15'h1,   32'h0,        1'b1, 4'hF, 15'h2,   32'h55667788, 1'b0, 1'b0, 32'hDEAD1122, 1'b0, 1'b0, 32'hCAFEF00D, 16'd1};
    v[14] = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 1'b1, 32'h11223344, 1'b1, 1'b0, 32'hCAFEF00D, 16'd1};
    v[15] = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 4'h0, 15'h2,   32'h0,        1'b1, 1'b0, 32'h11223344, 1'b0, 1'b0, 32'hCAFEF00D, 16'd1};
    v[16] = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 1'b0, 32'h11223344, 1'b1, 1'b1, 32'h55667788, 16'd1};
    v[17] = '{1'b1, 4'hF, 15'h3,   32'hAAAAAAAA, 1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 1'b0, 32'h11223344, 1'b1, 1'b0, 32'h55667788, 16'd1};
    v[18] = '{1'b1, 4'h0, 15'h10,  32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 1'b0, 32'h11223344, 1'b1, 1'b0, 32'h55667788, 16'd1};
    v[19] = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 1'b0, 32'h11223344, 1'b1, 1'b0, 32'h55667788, 16'd1};
    v[20] = '{1'b1, 4'h0, 15'h10,  32'h0,        1'b1, 4'h0, 15'h10,  32'h0,        1'b0, 1'b0, 32'h11223344, 1'b0, 1'b0, 32'h55667788, 16'd1};
    v[21] = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 1'b1, 32'hDEAD1122, 1'b1, 1'b1, 32'hDEAD1122, 16'd1};
    v[22] = '{1'b1, 4'h1, 15'h3,   32'h01010101, 1'b1, 4'h2, 15'h3,   32'h02020202, 1'b0, 1'b0, 32'hDEAD1122, 1'b0, 1'b0, 32'hDEAD1122, 16'd1};
    v[23] = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 1'b0, 32'hDEAD1122, 1'b0, 1'b0, 32'hDEAD1122, 16'd2};
    v[24] = '{1'b1, 4'h0, 15'h3,   32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 1'b0, 32'hDEAD1122, 1'b1, 1'b0, 32'hDEAD1122, 16'd2};
    v[25] = '{1'b0, 4'h0, 15'h0,   32'h0,        1'b0, 4'h0, 15'h0,   32'h0,        1'b1, 1'b1, 32'hAAAA0201, 1'b1, 1'b0, 32'hDEAD1122, 16'd2};
    d2 = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
    tick();
    tick();
    rst = 0;
    chk("rst doneA", 32'(done_a), 32'd1);
    chk("rst doneB", 32'(done_b), 32'd1);
    chk("rst validA", 32'(valid_a), 32'd0);
    chk("rst validB", 32'(valid_b), 32'd0);
    chk("rst doutA", dout_a, 32'h0);
    chk("rst doutB", dout_b, 32'h0);
    chk("rst count", 32'(cnt), 32'd0);
    for (int k = 0; k < 26; k++) begin
      req_a = v[k].ra; we_a = v[k].wa; addr_a = v[k].aa; din_a = v[k].da;
      req_b = v[k].rb; we_b = v[k].wb; addr_b = v[k].ab; din_b = v[k].db;
      tick();
      chk($sformatf("v%0d doneA", k), 32'(done_a), 32'(v[k].eda));
      chk($sformatf("v%0d validA", k), 32'(valid_a), 32'(v[k].eva));
      chk($sformatf("v%0d doutA", k), dout_a, v[k].eqa);
      chk($sformatf("v%0d doneB", k), 32'(done_b), 32'(v[k].edb));
      chk($sformatf("v%0d validB", k), 32'(valid_b), 32'(v[k].evb));
      chk($sformatf("v%0d doutB", k), dout_b, v[k].eqb);
      chk($sformatf("v%0d count", k), 32'(cnt), 32'(v[k].ec));
    end
    req_a = 1; we_a = 4'h0; addr_a = 15'h10;
    req_b = 1; we_b = 4'hF; addr_b = 15'h10; din_b = 32'hFFFFFFFF;
    tick();
    req_a = 0; req_b = 0; rst = 1;
    chk("midrst busyA", 32'(done_a), 32'd0);
    repeat (3) tick();
    rst = 0;
    chk("postrst doneA", 32'(done_a), 32'd1);
    chk("postrst validA", 32'(valid_a), 32'd0);
    chk("postrst doutA", dout_a, 32'h0);
    chk("postrst doneB", 32'(done_b), 32'd1);
    chk("postrst count", 32'(cnt), 32'd0);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      pulses += int'(valid_a) + int'(valid_b);
    end
    chk("postrst no valid pulse", 32'(pulses), 32'd0);
    req_a = 1; we_a = 4'h0; addr_a = 15'h10;
    tick();
    req_a = 0;
    tick();
    chk("postrst read valid", 32'(valid_a), 32'd1);
    chk("postrst write dropped", dout_a, 32'hDEAD1122);
    for (int i = 0; i < 3; i++) begin
      r2_req_a = 1; r2_we_a = 4'hF; r2_addr_a = 15'(i); r2_din_a = d2[i];
      tick();
      r2_req_a = 0;
      tick();
    end
    r2_req_b = 1; r2_addr_b = 15'h0;
    tick();
    r2_req_b = 0;
    n = 0; last = 0; low = 0; maxlow = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      low = r2_done_b ? 0 : low + 1;
      if (low > maxlow) maxlow = low;
      if (r2_valid_b) begin
        chk($sformatf("rl2 dout%0d", n), r2_dout_b, d2[n]);
        chk($sformatf("rl2 spacing%0d", n), 32'(c - last), n == 0 ? 32'd2 : 32'd3);
        last = c;
        n++;
        if (n < 3) begin
          r2_req_b = 1;
          r2_addr_b = 15'(n);
        end
      end
      tick();
      r2_req_b = 0;
    end
    chk("rl2 pulses seen", 32'(n), 32'd3);
    chk("rl2 max busy run", 32'(maxlow), 32'd2);
    chk("rl2 valid drops", 32'(r2_valid_b), 32'd0);
    chk("rl2 dout holds", r2_dout_b, d2[2]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
